// File: rtl/row_clear_engine_if.sv
// -----------------------------------------------------------------------------
// row_clear_engine_if
// Bundles the merge, scan/clear handshake and display-read signals of
// row_clear_engine. The clock and reset stay plain ports on the module.
//
// Signals (slave = row_clear_engine view):
//   land_we, land_row, land_bits   in   merge request: board[land_row] |= land_bits
//   scan_start, clear_start        in   single-cycle start pulses
//   which_row                      out  last scan result, ROWS when no row is full
//   scan_done, clear_done          out  single-cycle completion pulses
//   busy                           out  high while scanning or shifting
//   rd_row                         in   display read address
//   rd_data                        out  board[rd_row], 0 when out of range
//   top_out                        out  any cell set in the top row
//   lines_cleared                  out  saturating clear count (LINE_COUNT_EN only)
//
// Optional feature macro: LINE_COUNT_EN
// -----------------------------------------------------------------------------
interface row_clear_engine_if #(
    parameter int WIDTH = 8
) ();
    logic             land_we;
    logic [3:0]       land_row;
    logic [WIDTH-1:0] land_bits;
    logic             scan_start;
    logic             clear_start;
    logic [3:0]       which_row;
    logic             scan_done;
    logic             clear_done;
    logic             busy;
    logic [3:0]       rd_row;
    logic [WIDTH-1:0] rd_data;
    logic             top_out;
`ifdef LINE_COUNT_EN
    logic [7:0]       lines_cleared;
`endif

    modport master (
`ifdef LINE_COUNT_EN
        input  lines_cleared,
`endif
        output land_we, land_row, land_bits, scan_start, clear_start, rd_row,
        input  which_row, scan_done, clear_done, busy, rd_data, top_out
    );

    modport slave (
`ifdef LINE_COUNT_EN
        output lines_cleared,
`endif
        input  land_we, land_row, land_bits, scan_start, clear_start, rd_row,
        output which_row, scan_done, clear_done, busy, rd_data, top_out
    );
endinterface

// File: rtl/row_clear_engine.sv
// -----------------------------------------------------------------------------
// row_clear_engine
// Playfield store for the Tetris chip. Merges landed piece rows, scans upward
// for the lowest full row, and shifts the board down over a cleared row.
//
// Ports:
//   clka     in   sole clock, rising edge
//   restart  in   asynchronous active-high reset (board cleared, IDLE)
//   bus      row_clear_engine_if.slave (merge, scan/clear handshake, display read)
//
// Parameters: WIDTH (bits per row), ROWS (2..15, row 0 at the bottom).
// Optional feature macro: LINE_COUNT_EN adds the saturating lines_cleared counter.
//
// State  | Meaning
// -------+-----------------------------------------------------------------
// IDLE   | accepts merges and start pulses; done pulses are seen here
// SCAN   | examines board[p] once per cycle, p counting up from 0
// SHIFT  | copies board[p+1] into board[p], p counting up to ROWS-1
// -----------------------------------------------------------------------------
module row_clear_engine #(
    parameter int WIDTH = 8,
    parameter int ROWS  = 11
) (
    input  logic               clka,
    input  logic               restart,
    row_clear_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    localparam logic [3:0] SENT = 4'(ROWS);
    localparam logic [3:0] LAST = 4'(ROWS - 1);

    state_t           state_q, state_d;
    logic [3:0]       p_q, p_d;
    logic [3:0]       which_q, which_d;
    logic             scan_done_q, scan_done_d;
    logic             clear_done_q, clear_done_d;
    logic [WIDTH-1:0] board_q [ROWS];
    logic [WIDTH-1:0] board_d [ROWS];
`ifdef LINE_COUNT_EN
    logic [7:0]       lines_q, lines_d;
`endif

    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_q      <= S_IDLE;
            p_q          <= '0;
            which_q      <= SENT;
            scan_done_q  <= 1'b0;
            clear_done_q <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                board_q[i] <= '0;
            end
`ifdef LINE_COUNT_EN
            lines_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            which_q      <= which_d;
            scan_done_q  <= scan_done_d;
            clear_done_q <= clear_done_d;
            board_q      <= board_d;
`ifdef LINE_COUNT_EN
            lines_q      <= lines_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        which_d      = which_q;
        scan_done_d  = 1'b0;
        clear_done_d = 1'b0;
        board_d      = board_q;
`ifdef LINE_COUNT_EN
        lines_d      = lines_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.land_we && (bus.land_row < SENT)) begin
                    board_d[bus.land_row] = board_q[bus.land_row] | bus.land_bits;
                end
                // scan_start has priority; a simultaneous clear_start is dropped.
                if (bus.scan_start) begin
                    state_d = S_SCAN;
                    p_d     = '0;
                end else if (bus.clear_start) begin
                    if (which_q < SENT) begin
                        state_d = S_SHIFT;
                        p_d     = which_q;
                    end else begin
                        // Nothing to clear: acknowledge without touching the board.
                        clear_done_d = 1'b1;
                    end
                end
            end

            S_SCAN: begin
                if (&board_q[p_q]) begin
                    which_d     = p_q;
                    scan_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (p_q == LAST) begin
                    which_d     = SENT;
                    scan_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    p_d = p_q + 4'd1;
                end
            end

            S_SHIFT: begin
                if (p_q == LAST) begin
                    board_d[p_q] = '0;
                    clear_done_d = 1'b1;
                    which_d      = SENT;
                    state_d      = S_IDLE;
`ifdef LINE_COUNT_EN
                    if (lines_q != 8'hFF) begin
                        lines_d = lines_q + 8'd1;
                    end
`endif
                end else begin
                    board_d[p_q] = board_q[p_q + 4'd1];
                    p_d          = p_q + 4'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.which_row  = which_q;
    assign bus.scan_done  = scan_done_q;
    assign bus.clear_done = clear_done_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.rd_data    = (bus.rd_row < SENT) ? board_q[bus.rd_row] : '0;
    assign bus.top_out    = |board_q[ROWS-1];
`ifdef LINE_COUNT_EN
    assign bus.lines_cleared = lines_q;
`endif

endmodule

// File: tb/tb_row_clear_engine.sv
module tb_row_clear_engine;
    localparam int WIDTH = 8;
    localparam int ROWS  = 11;

    logic clka    = 1'b0;
    logic restart = 1'b1;

    row_clear_engine_if #(.WIDTH(WIDTH)) bus ();

    row_clear_engine #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
        .clka    (clka),
        .restart (restart),
        .bus     (bus)
    );

    always #10 clka = ~clka;

    int nvec = 0;
    int nerr = 0;

    // Reference model: board as an array of rows, last scan result, line count.
    logic [WIDTH-1:0] mb [ROWS];
    int mw;
    int ml;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < ROWS; i++) mb[i] = '0;
        mw = ROWS;
        ml = 0;
    endtask

    task automatic model_land(input int r, input logic [WIDTH-1:0] b);
        if (r < ROWS) mb[r] = mb[r] | b;
    endtask

    function automatic int model_full();
        for (int i = 0; i < ROWS; i++) begin
            if (mb[i] == {WIDTH{1'b1}}) return i;
        end
        return ROWS;
    endfunction

    // Reads every address (including out-of-range ones) within one clock period.
    task automatic check_board(input string tag);
        logic [WIDTH-1:0] e;
        logic t;
        for (int r = 0; r < 16; r++) begin
            bus.rd_row = 4'(r);
            #1;
            e = (r < ROWS) ? mb[r] : '0;
            chk({tag, "_rd"}, 32'(bus.rd_data), 32'(e));
        end
        t = |mb[ROWS-1];
        chk({tag, "_top"}, 32'(bus.top_out), 32'(t));
`ifdef LINE_COUNT_EN
        chk({tag, "_lines"}, 32'(bus.lines_cleared), 32'(ml));
`endif
    endtask

    task automatic do_reset();
        restart = 1'b1;
        tick();
        tick();
        restart = 1'b0;
        model_reset();
        chk("rst_which", 32'(bus.which_row), 32'(ROWS));
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_sdone", 32'(bus.scan_done), 0);
        chk("rst_cdone", 32'(bus.clear_done), 0);
        check_board("rst");
        tick();
    endtask

    task automatic land(input int r, input logic [WIDTH-1:0] b);
        bus.land_we   = 1'b1;
        bus.land_row  = 4'(r);
        bus.land_bits = b;
        tick();
        bus.land_we = 1'b0;
        model_land(r, b);
    endtask

    task automatic run_scan(input bit with_clear, input bit with_land, input bit land_in_scan);
        int r, k, exp_n, n;
        logic [WIDTH-1:0] b;
        bit busy_ok;
        r = $urandom_range(0, ROWS - 1);
        b = (($urandom % 2) == 0) ? {WIDTH{1'b1}} : WIDTH'($urandom);
        bus.scan_start = 1'b1;
        if (with_clear) bus.clear_start = 1'b1;
        if (with_land) begin
            bus.land_we   = 1'b1;
            bus.land_row  = 4'(r);
            bus.land_bits = b;
        end
        tick();
        bus.scan_start  = 1'b0;
        bus.clear_start = 1'b0;
        bus.land_we     = 1'b0;
        if (with_land) model_land(r, b);
        k = model_full();
        exp_n = (k == ROWS) ? ROWS : k + 1;
        n = 0;
        busy_ok = 1'b1;
        while (!bus.scan_done && n < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (land_in_scan) begin
                bus.land_we   = 1'b1;
                bus.land_row  = 4'($urandom_range(0, ROWS - 1));
                bus.land_bits = WIDTH'($urandom) | 8'h01;
            end
            tick();
            n++;
        end
        bus.land_we = 1'b0;
        chk("scan_latency", 32'(n), 32'(exp_n));
        chk("scan_busy", 32'(busy_ok), 1);
        chk("scan_which", 32'(bus.which_row), 32'(k));
        chk("scan_busy_end", 32'(bus.busy), 0);
        mw = k;
        tick();
        chk("scan_pulse", 32'(bus.scan_done), 0);
    endtask

    task automatic run_clear();
        int k, exp_n, n;
        bit busy_ok;
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        k = mw;
        exp_n = (k == ROWS) ? 0 : ROWS - k;
        n = 0;
        busy_ok = 1'b1;
        while (!bus.clear_done && n < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            tick();
            n++;
        end
        chk("clr_latency", 32'(n), 32'(exp_n));
        chk("clr_busy", 32'(busy_ok), 1);
        chk("clr_busy_end", 32'(bus.busy), 0);
        if (k < ROWS) begin
            for (int i = k; i < ROWS - 1; i++) mb[i] = mb[i + 1];
            mb[ROWS-1] = '0;
            if (ml < 255) ml++;
        end
        mw = ROWS;
        chk("clr_which", 32'(bus.which_row), 32'(ROWS));
        tick();
        chk("clr_pulse", 32'(bus.clear_done), 0);
        check_board("clr");
    endtask

    task automatic rand_land();
        int r;
        logic [WIDTH-1:0] b;
        r = $urandom_range(0, 13);
        b = ($urandom_range(0, 9) < 4) ? {WIDTH{1'b1}} : WIDTH'($urandom);
        land(r, b);
    endtask

    initial begin
        bus.land_we     = 1'b0;
        bus.land_row    = '0;
        bus.land_bits   = '0;
        bus.scan_start  = 1'b0;
        bus.clear_start = 1'b0;
        bus.rd_row      = '0;
        model_reset();

        // Reset state and empty-board scan.
        do_reset();
        run_scan(0, 0, 0);
        chk("empty_which", 32'(bus.which_row), 32'(ROWS));

        // Single full row at 3.
        land(3, 8'hFF);
        run_scan(0, 0, 0);
        chk("row3_which", 32'(bus.which_row), 3);

        // Two full rows plus partial rows; clear lowest, rescan.
        do_reset();
        land(2, 8'hFF);
        land(5, 8'hFF);
        land(4, 8'h81);
        land(10, 8'h01);
        run_scan(0, 0, 0);
        chk("multi_which", 32'(bus.which_row), 2);
        run_clear();
        chk("multi_row3", 32'(mb[3]), 32'h81);
        run_scan(0, 0, 0);
        chk("multi_rescan", 32'(bus.which_row), 4);
        run_clear();
        // No full row recorded: immediate acknowledge, board and count unchanged.
        run_clear();

        // Restart in the middle of a shift.
        do_reset();
        land(1, 8'hFF);
        land(6, 8'h3C);
        run_scan(0, 0, 0);
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        repeat (4) tick();
        #2;
        restart = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_which", 32'(bus.which_row), 32'(ROWS));
        chk("mid_rst_cdone", 32'(bus.clear_done), 0);
        repeat (3) begin
            tick();
            chk("mid_rst_nodone", 32'(bus.clear_done), 0);
        end
        check_board("mid_rst");
        restart = 1'b0;
        tick();

        // Ignored merge during scan, simultaneous starts, top-out.
        land(0, 8'hFF);
        run_scan(0, 0, 1);
        check_board("scan_land");
        run_scan(1, 0, 0);
        check_board("scan_clear");
        land(ROWS - 1, 8'h10);
        check_board("topout");
        chk("topout_flag", 32'(bus.top_out), 1);

        // Randomised sequences against the model.
        do_reset();
        repeat (120) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rand_land();
                4:          run_scan($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                5, 6, 7:    begin run_scan(0, $urandom_range(0, 1) == 1, 0); run_clear(); end
                8:          run_clear();
                default:    check_board("rand");
            endcase
        end
        check_board("rand_end");

`ifdef LINE_COUNT_EN
        do_reset();
        repeat (256) begin
            land(0, 8'hFF);
            run_scan(0, 0, 0);
            run_clear();
        end
        chk("sat_lines", 32'(bus.lines_cleared), 255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/row_clear_engine.md
# row_clear_engine

Board-state store and row-clear datapath for the Tetris chip; sits directly upstream and downstream of the main FSM. It merges landed piece rows into the playfield and scans for a full row while the FSM is in LAND, returning `which_row`. It shifts the playfield down over that row while the FSM is in CLEAR. It also exposes a read port for the display path and a top-out flag.

## Interface
Parameters:
- `WIDTH`, default 8: playfield columns, bits per row.
- `ROWS`, default 11: playfield rows, legal range 2..15. Row 0 is the bottom row. The no-full-row sentinel equals `ROWS`, which is 4'b1011 at the default.

Ports:
- `clka`, input, 1: sole clock; all state updates on its rising edge.
- `restart`, input, 1: asynchronous, active-high reset.
- `land_we`, input, 1: merge request; OR `land_bits` into row `land_row`.
- `land_row`, input, 4: target row of the merge.
- `land_bits`, input, WIDTH: cells to set.
- `scan_start`, input, 1: single-cycle pulse; begin full-row scan.
- `clear_start`, input, 1: single-cycle pulse; begin shift-down over `which_row`.
- `which_row`, output, 4: result of the last scan. Value is `ROWS` when no row is full.
- `scan_done`, output, 1: single-cycle pulse; `which_row` valid.
- `clear_done`, output, 1: single-cycle pulse; shift complete.
- `busy`, output, 1: high in SCAN or SHIFT.
- `rd_row`, input, 4: display read address.
- `rd_data`, output, WIDTH: combinational board[`rd_row`]. Returns 0 if `rd_row` ≥ `ROWS`.
- `top_out`, output, 1: combinational OR of board[`ROWS`-1].
- `lines_cleared`, output, 8: only with `LINE_COUNT_EN`.

## Operation
- States: IDLE, SCAN, SHIFT. Reset state is IDLE.
- IDLE behaviour:
  - `land_we` is accepted only in IDLE. board[`land_row`] |= `land_bits` at the edge.
  - A `land_row` ≥ `ROWS` is ignored.
  - `land_we` in SCAN or SHIFT is ignored with no effect.
- IDLE transitions:
  - `scan_start` → SCAN, with row pointer p = 0.
  - `clear_start` with `which_row` < `ROWS` → SHIFT, with p = `which_row`.
  - `clear_start` with `which_row` == `ROWS` → stay in IDLE and pulse `clear_done` next cycle. Board is unchanged.
  - If `scan_start` and `clear_start` arrive in the same cycle, `scan_start` wins and `clear_start` is dropped.
  - `scan_start` or `clear_start` while busy is ignored.
- SCAN: examine board[p] each cycle.
  - If all WIDTH bits are set: `which_row` ← p, pulse `scan_done`, → IDLE.
  - Else if p == `ROWS`-1: `which_row` ← `ROWS`, pulse `scan_done`, → IDLE.
  - Else p ← p+1.
  - The lowest full row always wins. The FSM re-scans after each CLEAR to catch further rows.
- SHIFT: each cycle board[p] ← board[p+1] and p ← p+1.
  - When p == `ROWS`-1, board[`ROWS`-1] ← 0, pulse `clear_done`, → IDLE.
  - `which_row` is set to `ROWS` when the shift finishes.
- `restart` at any time, including mid-SCAN or mid-SHIFT:
  - board cleared to 0, state IDLE, `which_row` = `ROWS`.
  - `scan_done`, `clear_done` and `busy` forced to 0; counter cleared.
- Reset values: `which_row` = `ROWS`; `scan_done` = `clear_done` = `busy` = 0; `rd_data` = 0 and `top_out` = 0 because the board is empty; `lines_cleared` = 0.

## Timing
- `land_we` sampled at edge E is visible on `rd_data` after E.
- `land_we` and `scan_start` in the same IDLE cycle: the merge commits at E and the scan reads row 0 at E+1, so the merge is seen.
- `scan_start` at edge E: row p is examined in cycle E+1+p.
  - Full row at k: `scan_done` is high during cycle E+1+k, and `which_row` updates at the same edge that raises `scan_done`.
  - No full row: latency is `ROWS` cycles.
- `clear_start` at edge E with `which_row` = k: `clear_done` is high `ROWS`-k cycles after E.
- `busy` is high from the edge after the accepted start through the edge that drops it, together with the done pulse.
- Done pulses last exactly one cycle, and the block is back in IDLE in that cycle, so a new start is accepted immediately.

## Configuration
- `LINE_COUNT_EN` defined:
  - `lines_cleared` is an 8-bit counter, incremented by 1 on each `clear_done` that follows an actual shift.
  - It saturates at 255 and is cleared by `restart`.
- `LINE_COUNT_EN` undefined: the `lines_cleared` port and counter are absent, and all other behaviour is identical.

## Test plan
- Empty board after `restart`, `scan_start` → `scan_done` after 11 cycles, `which_row` = 4'b1011, `busy` high for those 11 cycles.
- Fill row 3 with `land_we`, `land_bits` = 8'hFF, then `scan_start` → `scan_done` 4 cycles later with `which_row` = 3.
- Rows 2 and 5 full, row 4 = 8'h81, row 10 = 8'h01:
  - `scan_start` → `which_row` = 2.
  - `clear_start` → `clear_done` 9 cycles later.
  - Then row 3 = 8'h81, row 4 = 8'hFF, row 9 = 8'h01, row 10 = 0, `which_row` = 11, `lines_cleared` = 1.
  - A second scan returns 4.
- `clear_start` with `which_row` = 11 → `clear_done` next cycle, board unchanged, counter unchanged.
- Assert `restart` during cycle 5 of a SHIFT → board all zero, `busy` = 0, no `clear_done`, `which_row` = 11.
- `land_we` during SCAN is ignored.
  - `scan_start` and `clear_start` together in IDLE → only the scan runs.
  - Set row 10 = 8'h10 → `top_out` = 1.
  - With `LINE_COUNT_EN`, 256 clears leave `lines_cleared` = 255.
